// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scanner: font table, widths and
// converter state encoding.
package seg_pkg;

  localparam int unsigned BIN_W      = 14;
  localparam int unsigned SH_W       = 16;
  localparam int unsigned BCD_W      = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [15:0] MAX_VAL    = 16'd9999;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_FONT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_e;

  // Active-low g..a pattern for one BCD nibble; non-decimal nibbles go dark.
  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    logic [6:0] f;
    f = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (nib == 4'(i)) f = SEG_FONT[i];
    end
    return f;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to 4 BCD digits,
// one shift per clock.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  conv_state_e      state, state_nx;
  logic [SH_W-1:0]  sh, sh_nx;
  logic [BCD_W-1:0] bcd_nx, adj_c;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             busy_nx, done_nx;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      sh    <= sh_nx;
      bcd   <= bcd_nx;
      cnt   <= cnt_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  // Next state: load on start, then 16 add-3/shift steps and one closing cycle
  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    bcd_nx   = bcd;
    cnt_nx   = cnt;
    busy_nx  = busy;
    done_nx  = 1'b0;
    adj_c    = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    case (state)
      IDLE: begin
        if (start) begin
          sh_nx    = SH_W'(bin);
          bcd_nx   = '0;
          cnt_nx   = CNT_W'(SH_W);
          busy_nx  = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          {bcd_nx, sh_nx} = {adj_c[BCD_W-2:0], sh, 1'b0};
          cnt_nx          = cnt - CNT_W'(1);
          done_nx         = (cnt == CNT_W'(1));
        end else begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/seg_display_scan.sv
// Binary value to 4-digit multiplexed common-anode 7-segment display with
// leading-zero blanking and whole-display blink.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic        busy,
  output logic [15:0] bcd_out,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [15:0]        last_value;
  logic               start_c;
  logic [BIN_W-1:0]   bin_c;
  logic [BCD_W-1:0]   conv_bcd;
  logic               conv_done;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [1:0]         idx;
  logic               phase;
  logic               lz_c;
  logic [3:0]         an_nx;
  logic [7:0]         seg_nx;

  // Convert only when idle and the input moved; out-of-range values saturate
  assign start_c = !busy && (value_in != last_value);
  assign bin_c   = (value_in > MAX_VAL) ? MAX_VAL[BIN_W-1:0] : value_in[BIN_W-1:0];

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_c),
    .bin   (bin_c),
    .busy  (busy),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // Change detector and displayed-value latch (only complete conversions)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_value <= '0;
      bcd_out    <= '0;
    end else begin
      if (start_c)   last_value <= value_in;
      if (conv_done) bcd_out    <= conv_bcd;
    end
  end

  // Digit scan and blink timebases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Digit enable and segment pattern for the current digit
  always_comb begin
    lz_c = blank_lz && (idx != 2'd0);
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(idx) && bcd_out[4*i +: 4] != 4'd0) lz_c = 1'b0;
    end
    an_nx = ~(4'b0001 << idx);
    if (lz_c) an_nx[idx] = 1'b1;
    if (blink_en && phase) an_nx = 4'hF;
    seg_nx = {1'b1, seg_font(bcd_out[{idx, 2'b00} +: 4])};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'hF;
      seg <= 8'hFF;
    end else begin
      an  <= an_nx;
      seg <= seg_nx;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Randomized bench for seg_display_scan against a cycle-count based
// decimal reference model.
module tb_seg_display_scan;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLINK_DIV = 32;
  localparam int          CONV_LAT  = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value_in;
  logic        blank_lz;
  logic        blink_en;
  logic        busy;
  logic [15:0] bcd_out;
  logic [3:0]  an;
  logic [7:0]  seg;

  always #5 clk = ~clk;

  seg_display_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_in (value_in),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .busy     (busy),
    .bcd_out  (bcd_out),
    .an       (an),
    .seg      (seg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: display shows a decimal number; timing derived from edge count
  int        m_k, m_last, m_rem, m_target, m_disp;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic [6:0] font [0:9];

  initial begin
    font[0] = 7'h40; font[1] = 7'h79; font[2] = 7'h24; font[3] = 7'h30; font[4] = 7'h19;
    font[5] = 7'h12; font[6] = 7'h02; font[7] = 7'h78; font[8] = 7'h00; font[9] = 7'h10;
  end

  function automatic int to_bcd(input int d);
    return (d % 10) | (((d / 10) % 10) << 4) | (((d / 100) % 10) << 8) | (((d / 1000) % 10) << 12);
  endfunction

  task automatic model_reset();
    m_k = 0; m_last = 0; m_rem = 0; m_target = 0; m_disp = 0;
  endtask

  task automatic model_edge();
    int idx, pw, ph, v;
    idx = (m_k / int'(SCAN_DIV)) % 4;
    ph  = (m_k / int'(BLINK_DIV)) % 2;
    pw  = 1;
    for (int i = 0; i < idx; i++) pw = pw * 10;
    exp_an = 4'hF;
    exp_an[idx] = 1'b0;
    if (blank_lz && idx > 0 && m_disp < pw) exp_an = 4'hF;
    if (blink_en && ph == 1) exp_an = 4'hF;
    exp_seg = {1'b1, font[(m_disp / pw) % 10]};
    v = int'(value_in);
    if (m_rem == 0 && v != m_last) begin
      m_last   = v;
      m_target = (v > 9999) ? 9999 : v;
      m_rem    = CONV_LAT;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_disp = m_target;
    end
    m_k++;
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      check("an", an, exp_an);
      check("seg", seg, exp_seg);
      check("busy", busy, (m_rem > 0));
      check("bcd_out", bcd_out, to_bcd(m_disp));
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_an"}, an, 4'hF);
    check({tag, "_seg"}, seg, 8'hFF);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_bcd"}, bcd_out, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0; value_in = 16'd0; blank_lz = 1'b1; blink_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;

    // Zero with blanking: no conversion, only the rightmost digit lit
    step(40);

    // Plain conversion and full four-digit scan
    blank_lz = 1'b0; value_in = 16'd1234;
    step(60);

    // Saturation, then a single digit with blanking
    value_in = 16'd50000;
    step(40);
    value_in = 16'd7; blank_lz = 1'b1;
    step(40);

    // Input change in the middle of a conversion
    value_in = 16'd1111;
    step(25);
    value_in = 16'd1234;
    step(5);
    value_in = 16'd5678;
    step(50);

    // Blinking, then continuous scan
    blink_en = 1'b1;
    step(150);
    blink_en = 1'b0;
    step(40);

    // Reset during a conversion, then a fresh conversion of the same input
    value_in = 16'd4321;
    step(6);
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    #20;
    rst_n = 1'b1;
    model_reset();
    step(40);

    // Randomized values, holds and control inputs
    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 3))
        0: value_in = 16'($urandom_range(0, 65535));
        1: value_in = 16'($urandom_range(0, 9999));
        2: value_in = 16'($urandom_range(0, 120));
        default: ;
      endcase
      blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) blink_en = ~blink_en;
      step(int'($urandom_range(1, 30)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
